// File: rtl/century_clock_pkg.sv
// Shared types and helpers for the century clock front end.
// Holds the auto-repeat state encoding and the ms-to-cycles conversion.
package century_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCKED = 2'd3
    } btn_rpt_state_t;

    localparam int unsigned BTN_UP   = 0;
    localparam int unsigned BTN_DOWN = 1;
    localparam int unsigned BTN_SEL  = 2;
    localparam int unsigned NUM_BTN  = 3;

    function automatic int unsigned ms_to_cycles(input int unsigned f_clk,
                                                 input int unsigned ms);
        return f_clk / 1000 * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce counter, stable level
// and a one-cycle strobe on each accepted press (stable 0 -> 1).
module btn_debounce
    import century_clock_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic held,
    output logic press
);

    localparam int unsigned CW = $clog2(DB_CYCLES);

    logic          raw_norm;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    assign raw_norm = ACTIVE_LOW ? ~raw : raw;

    always_comb begin
        sync1_d  = raw_norm;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            // Level has disagreed long enough: accept it and flag a press.
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
                press_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign held  = stable_q;
    assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the up/down/select buttons: debounced levels, press events,
// hold-to-repeat with up/down interlock, and sticky requests cleared by ack.
module button_conditioner
    import century_clock_pkg::*;
#(
    parameter int unsigned F_CLK           = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    input  logic btn_sel_raw,
    output logic up_pulse,
    output logic down_pulse,
    output logic sel_pulse,
    output logic up_req,
    output logic down_req,
    output logic sel_req,
    input  logic up_ack,
    input  logic down_ack,
    input  logic sel_ack,
    output logic up_held,
    output logic down_held,
    output logic sel_held
);

    localparam int unsigned DB_CYCLES = ms_to_cycles(F_CLK, DEBOUNCE_MS);
    localparam int unsigned RD_CYCLES = ms_to_cycles(F_CLK, REPEAT_DELAY_MS);
    localparam int unsigned RR_CYCLES = ms_to_cycles(F_CLK, REPEAT_RATE_MS);
    localparam int unsigned TMR_LIMIT = (RD_CYCLES > RR_CYCLES) ? RD_CYCLES : RR_CYCLES;
    localparam int unsigned TW        = $clog2(TMR_LIMIT);

    generate
        if (DB_CYCLES < 2 || RD_CYCLES < 2 || RR_CYCLES < 2) begin : g_bad_params
            $error("button_conditioner: every cycle limit must be at least 2");
        end
    endgenerate

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] ack_vec;
    logic [NUM_BTN-1:0] held_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [NUM_BTN-1:0] pulse_set_vec;
    logic [NUM_BTN-1:0] pulse_vec;
    logic [NUM_BTN-1:0] req_vec;

    assign raw_vec = {btn_sel_raw, btn_down_raw, btn_up_raw};
    assign ack_vec = {sel_ack, down_ack, up_ack};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic req_q, req_d;

            btn_debounce #(
                .DB_CYCLES  (DB_CYCLES),
                .ACTIVE_LOW (ACTIVE_LOW)
            ) u_debounce (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_vec[gi]),
                .held  (held_vec[gi]),
                .press (press_vec[gi])
            );

            // A new event on the same edge as an ack keeps the request set.
            always_comb begin
                req_d = pulse_set_vec[gi] | (req_q & ~ack_vec[gi]);
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    req_q <= 1'b0;
                end else begin
                    req_q <= req_d;
                end
            end

            assign req_vec[gi] = req_q;
        end

        for (gi = 0; gi < 2; gi++) begin : g_rpt
            localparam int OTHER = 1 - gi;

            btn_rpt_state_t state_q, state_d;
            logic [TW-1:0]  timer_q, timer_d;
            logic           pulse_q, pulse_d;

            always_comb begin
                state_d = state_q;
                timer_d = timer_q;
                pulse_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        timer_d = '0;
                        if (press_vec[gi]) begin
                            if (held_vec[OTHER]) begin
                                state_d = LOCKED;
                            end else begin
                                state_d = DELAY;
                                pulse_d = 1'b1;
                            end
                        end
                    end
                    DELAY: begin
                        // Release outranks interlock, which outranks expiry.
                        if (!held_vec[gi]) begin
                            state_d = IDLE;
                        end else if (held_vec[OTHER]) begin
                            state_d = LOCKED;
                        end else if (timer_q == TW'(RD_CYCLES - 1)) begin
                            state_d = REPEAT;
                            timer_d = '0;
                            pulse_d = 1'b1;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!held_vec[gi]) begin
                            state_d = IDLE;
                        end else if (held_vec[OTHER]) begin
                            state_d = LOCKED;
                        end else if (timer_q == TW'(RR_CYCLES - 1)) begin
                            timer_d = '0;
                            pulse_d = 1'b1;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!held_vec[gi]) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_q <= IDLE;
                    timer_q <= '0;
                    pulse_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    timer_q <= timer_d;
                    pulse_q <= pulse_d;
                end
            end

            assign pulse_set_vec[gi] = pulse_d;
            assign pulse_vec[gi]     = pulse_q;
        end
    endgenerate

    // Select has no repeat: each accepted press becomes one registered pulse.
    logic sel_pulse_q, sel_pulse_d;

    always_comb begin
        sel_pulse_d = press_vec[BTN_SEL];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_pulse_q <= 1'b0;
        end else begin
            sel_pulse_q <= sel_pulse_d;
        end
    end

    assign pulse_set_vec[BTN_SEL] = sel_pulse_d;
    assign pulse_vec[BTN_SEL]     = sel_pulse_q;

    assign up_pulse   = pulse_vec[BTN_UP];
    assign down_pulse = pulse_vec[BTN_DOWN];
    assign sel_pulse  = pulse_vec[BTN_SEL];
    assign up_req     = req_vec[BTN_UP];
    assign down_req   = req_vec[BTN_DOWN];
    assign sel_req    = req_vec[BTN_SEL];
    assign up_held    = held_vec[BTN_UP];
    assign down_held  = held_vec[BTN_DOWN];
    assign sel_held   = held_vec[BTN_SEL];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal timing
// expectations plus random button activity checked cycle by cycle.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] p_btn = 3'b000;   // pressed levels: [0] up, [1] down, [2] sel
    logic up_ack = 1'b0, down_ack = 1'b0, sel_ack = 1'b0;
    logic btn_up_raw, btn_down_raw, btn_sel_raw;
    logic up_pulse, down_pulse, sel_pulse;
    logic up_req, down_req, sel_req;
    logic up_held, down_held, sel_held;

    assign btn_up_raw   = ~p_btn[0];
    assign btn_down_raw = ~p_btn[1];
    assign btn_sel_raw  = ~p_btn[2];

    button_conditioner #(
        .F_CLK           (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (20),
        .REPEAT_RATE_MS  (5),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .btn_sel_raw  (btn_sel_raw),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .sel_pulse    (sel_pulse),
        .up_req       (up_req),
        .down_req     (down_req),
        .sel_req      (sel_req),
        .up_ack       (up_ack),
        .down_ack     (down_ack),
        .sel_ack      (sel_ack),
        .up_held      (up_held),
        .down_held    (down_held),
        .sel_held     (sel_held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input bit loud);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end else if (loud) begin
            $display("check %-24s cycle %0d got %0d ok", name, cyc, act);
        end
    endtask

    // Reference model: pressed samples pass a 2-deep delay line; the accepted
    // level flips after DB consecutive disagreeing samples. Repeat pulses fall
    // at fixed offsets from the press pulse: 0, RD, RD+RR, RD+2RR, ...
    int m_s1[3]    = '{default: 0};
    int m_s2[3]    = '{default: 0};
    int m_held[3]  = '{default: 0};
    int m_run[3]   = '{default: 0};
    int m_rose[3]  = '{default: 0};
    int m_pulse[3] = '{default: 0};
    int m_req[3]   = '{default: 0};
    int m_mode[2]  = '{default: 0};  // 0 released, 1 repeating, 2 locked out
    int m_t0[2]    = '{default: 0};
    int m_cyc      = 0;

    always @(posedge clk) begin : ref_model
        int nb[3];
        int ack[3];
        int held[3];
        int run[3];
        int rose[3];
        int pulse[3];
        int req[3];
        int mode[2];
        int t0[2];
        int d;
        nb[0] = int'(!btn_up_raw);
        nb[1] = int'(!btn_down_raw);
        nb[2] = int'(!btn_sel_raw);
        ack[0] = int'(up_ack);
        ack[1] = int'(down_ack);
        ack[2] = int'(sel_ack);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] <= 0; m_s2[i] <= 0; m_held[i] <= 0; m_run[i] <= 0;
                m_rose[i] <= 0; m_pulse[i] <= 0; m_req[i] <= 0;
            end
            for (int i = 0; i < 2; i++) begin
                m_mode[i] <= 0; m_t0[i] <= 0;
            end
        end else begin
            held = m_held; run = m_run; mode = m_mode; t0 = m_t0;
            for (int i = 0; i < 2; i++) begin
                pulse[i] = 0;
                if (mode[i] == 0) begin
                    if (m_rose[i] != 0) begin
                        if (m_held[1 - i] != 0) mode[i] = 2;
                        else begin mode[i] = 1; t0[i] = m_cyc; pulse[i] = 1; end
                    end
                end else if (m_held[i] == 0) begin
                    mode[i] = 0;
                end else if (mode[i] == 1) begin
                    if (m_held[1 - i] != 0) mode[i] = 2;
                    else begin
                        d = m_cyc - t0[i];
                        if (d >= RD && ((d - RD) % RR) == 0) pulse[i] = 1;
                    end
                end
            end
            pulse[2] = m_rose[2];
            for (int i = 0; i < 3; i++) begin
                req[i] = (pulse[i] != 0 || (m_req[i] != 0 && ack[i] == 0)) ? 1 : 0;
                rose[i] = 0;
                if (m_s2[i] != held[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        held[i] = 1 - held[i];
                        run[i] = 0;
                        rose[i] = held[i];
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_held <= held; m_run <= run; m_rose <= rose; m_pulse <= pulse;
            m_req <= req; m_mode <= mode; m_t0 <= t0;
            m_s2 <= m_s1; m_s1 <= nb;
        end
        m_cyc <= m_cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("up_pulse",   up_pulse,   m_pulse[0], 1'b0);
            chk("down_pulse", down_pulse, m_pulse[1], 1'b0);
            chk("sel_pulse",  sel_pulse,  m_pulse[2], 1'b0);
            chk("up_req",     up_req,     m_req[0],   1'b0);
            chk("down_req",   down_req,   m_req[1],   1'b0);
            chk("sel_req",    sel_req,    m_req[2],   1'b0);
            chk("up_held",    up_held,    m_held[0],  1'b0);
            chk("down_held",  down_held,  m_held[1],  1'b0);
            chk("sel_held",   sel_held,   m_held[2],  1'b0);
        end
    end

    function automatic logic pulse_bit(input int which);
        case (which)
            0:       return up_pulse;
            1:       return down_pulse;
            default: return sel_pulse;
        endcase
    endfunction

    function automatic logic held_bit(input int which);
        case (which)
            0:       return up_held;
            1:       return down_held;
            default: return sel_held;
        endcase
    endfunction

    function automatic logic [8:0] all_outs();
        return {up_pulse, down_pulse, sel_pulse, up_req, down_req, sel_req,
                up_held, down_held, sel_held};
    endfunction

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic wait_pulse(input int which, input int budget, output int lat);
        int start;
        start = cyc;
        lat = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pulse_bit(which)) begin
                lat = cyc - start;
                break;
            end
        end
    endtask

    task automatic wait_held(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (held_bit(which) === val) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int which, input int ncyc, output int n);
        n = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (pulse_bit(which)) n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, n, n2, t0, at, zeros, max_held;
        int offs[$];
        int exp_offs[6];
        int hold_left[3];
        exp_offs = '{0, 20, 25, 30, 35, 40};

        // Reset with up already pressed
        p_btn = 3'b001;
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("reset_outputs_zero", 32'(all_outs()), 32'd0, 1'b1);
        rst_n = 1'b1;
        wait_pulse(0, 30, lat);
        chk("rst_release_press_lat", lat, DB + 3, 1'b1);
        p_btn[0] = 1'b0;
        count_pulses(0, 20, n);
        chk("rst_press_single_pulse", n, 0, 1'b1);

        // Bouncing select: 1,0,1 in 2-cycle phases, then held
        p_btn[2] = 1'b1; step(2);
        p_btn[2] = 1'b0; step(2);
        p_btn[2] = 1'b1;
        wait_pulse(2, 20, lat);
        chk("sel_bounce_lat", lat, DB + 3, 1'b1);
        count_pulses(2, 15, n);
        chk("sel_bounce_extra", n, 0, 1'b1);
        p_btn[2] = 1'b0;
        step(12);

        // 3-cycle glitch on select
        p_btn[2] = 1'b1; step(3);
        p_btn[2] = 1'b0;
        max_held = 0; n = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (sel_pulse) n++;
            if (sel_held) max_held = 1;
        end
        chk("glitch_no_pulse", n, 0, 1'b1);
        chk("glitch_held_low", max_held, 0, 1'b1);

        // Auto-repeat on up, released so the last pulse is at offset 40
        p_btn[0] = 1'b1;
        wait_pulse(0, 20, lat);
        chk("up_press_lat", lat, DB + 3, 1'b1);
        t0 = cyc;
        offs.delete();
        offs.push_back(0);
        while (cyc < t0 + 70) begin
            step(1);
            if (cyc == t0 + 38) p_btn[0] = 1'b0;
            if (up_pulse) offs.push_back(cyc - t0);
        end
        chk("repeat_count", offs.size(), 6, 1'b1);
        for (int i = 0; i < 6 && i < offs.size(); i++)
            chk($sformatf("repeat_offset_%0d", i), offs[i], exp_offs[i], 1'b1);

        // Interlock: down pressed while up repeats
        p_btn[0] = 1'b1;
        wait_pulse(0, 20, lat);
        t0 = cyc;
        while (cyc < t0 + 20) step(1);
        p_btn[1] = 1'b1;
        wait_held(1, 1'b1, 20, at);
        chk("dn_held_rise", at - t0, 26, 1'b1);
        n = 0; n2 = 0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            if (up_pulse) n++;
            if (down_pulse) n2++;
        end
        chk("lock_up_pulses", n, 0, 1'b1);
        chk("lock_dn_pulses", n2, 0, 1'b1);
        p_btn[1] = 1'b0;
        n = 0; n2 = 0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            if (up_pulse) n++;
            if (down_pulse) n2++;
        end
        chk("lock_hold_up_pulses", n, 0, 1'b1);
        chk("lock_hold_dn_pulses", n2, 0, 1'b1);
        p_btn[0] = 1'b0;
        step(15);
        p_btn[0] = 1'b1;
        wait_pulse(0, 20, lat);
        chk("repress_after_lock", lat, DB + 3, 1'b1);
        p_btn[0] = 1'b0;
        step(15);

        // Handshake on up
        up_ack = 1'b1; step(1); up_ack = 1'b0;
        chk("req_cleared_pre", up_req, 0, 1'b1);
        p_btn[0] = 1'b1;
        wait_pulse(0, 20, lat);
        t0 = cyc;
        n = 1; zeros = (up_req == 1'b1) ? 0 : 1;
        while (cyc < t0 + 29) begin
            step(1);
            if (up_pulse) n++;
            if (!up_req) zeros++;
        end
        chk("hs_three_pulses", n, 3, 1'b1);
        chk("hs_req_never_low", zeros, 0, 1'b1);
        up_ack = 1'b1; step(1);
        chk("hs_pulse_with_ack", up_pulse, 1, 1'b1);
        chk("hs_req_set_wins", up_req, 1, 1'b1);
        up_ack = 1'b0; step(1);
        chk("hs_req_still_set", up_req, 1, 1'b1);
        up_ack = 1'b1; step(1);
        chk("hs_req_cleared", up_req, 0, 1'b1);
        up_ack = 1'b0;
        p_btn[0] = 1'b0;
        step(20);

        // Down released so its held level drops right as DELAY would expire
        p_btn[1] = 1'b1;
        wait_pulse(1, 20, lat);
        t0 = cyc;
        while (cyc < t0 + 13) step(1);
        p_btn[1] = 1'b0;
        n = 0; at = -1;
        while (cyc < t0 + 40) begin
            step(1);
            if (down_pulse) n++;
            if (at < 0 && !down_held) at = cyc;
        end
        chk("rel_vs_exp_held_fall", at - t0, 19, 1'b1);
        chk("rel_vs_exp_no_pulse", n, 0, 1'b1);
        p_btn[1] = 1'b1;
        wait_pulse(1, 20, lat);
        chk("rel_vs_exp_idle", lat, DB + 3, 1'b1);
        p_btn[1] = 1'b0;
        step(15);

        // Reset asserted mid-hold
        p_btn[0] = 1'b1;
        wait_pulse(0, 20, lat);
        step(5);
        rst_n = 1'b0; step(3);
        chk("midhold_reset_zero", 32'(all_outs()), 32'd0, 1'b1);
        rst_n = 1'b1;
        wait_pulse(0, 20, lat);
        chk("midhold_repress_lat", lat, DB + 3, 1'b1);
        p_btn[0] = 1'b0;
        count_pulses(0, 20, n);
        chk("midhold_single_pulse", n, 0, 1'b1);

        // Random activity with occasional acks and resets
        for (int i = 0; i < 3; i++) hold_left[i] = $urandom_range(1, 30);
        for (int c = 0; c < 3000; c++) begin
            step(1);
            for (int i = 0; i < 3; i++) begin
                if (hold_left[i] == 0) begin
                    p_btn[i] = ~p_btn[i];
                    hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                               : $urandom_range(6, 45);
                end else begin
                    hold_left[i]--;
                end
            end
            up_ack   = ($urandom_range(0, 7) == 0);
            down_ack = ($urandom_range(0, 7) == 0);
            sel_ack  = ($urandom_range(0, 7) == 0);
            rst_n    = ($urandom_range(0, 599) != 0);
        end
        rst_n = 1'b1;
        up_ack = 1'b0; down_ack = 1'b0; sel_ack = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
